serial_pattern_tx: RTL and testbench
====================================

# serial_pattern_tx

Serial pattern transmitter that produces the single-bit `x` stream consumed by the `moore_pass` / `mealy_pass` sequence detectors. It accepts a parallel pattern word plus bit length and repeat count through a start strobe, then serializes it MSB-first, one bit per clock. It reports progress with `busy` and a one-cycle `done` pulse. It replaces hand-written `@(posedge clk) x <= ...` stimulus with a synthesizable source that can sit on-chip ahead of a detector.

## Interface
- `WIDTH`, 16: maximum pattern length in bits.
- `REP_W`, 4: width of the repeat-count field.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request to send; sampled only when `busy`=0.
- `abort` input 1: synchronous cancel of the transfer in progress.
- `pattern` input WIDTH: bits to send; bit `len-1` goes first, bit 0 last.
- `len` input $clog2(WIDTH)+1: number of bits per pass (valid range 1..WIDTH).
- `rep` input REP_W: extra passes; total passes = `rep`+1.
- `x` output 1: serial data bit, registered.
- `x_valid` output 1: high while `x` carries a pattern bit.
- `busy` output 1: high from the first bit through the last bit.
- `done` output 1: one-cycle pulse after the last bit of the last pass.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `x`=0, `x_valid`=0, `busy`=0.
  - On `start`=1, `abort`=0 and `len`≠0: capture `pattern`, `len` and `rep` into internal registers, then go to SHIFT.
  - The bit index is loaded with `len-1`, and `x` is loaded with `pattern[len-1]` at the same edge.
- **SHIFT**
  - Each edge: the bit index decrements and `x` takes `pat_q[idx]`.
  - When the index reaches 0 and passes remain: reload the index to `len_q-1` and decrement the pass counter. There is no gap cycle between passes.
  - When the index reaches 0 on the last pass: go to DONE.
- **DONE**
  - Lasts one cycle: `done`=1, `x`=0, `x_valid`=0, `busy`=0.
  - Always returns to IDLE; `start` in this cycle is ignored.
- `abort`=1 in SHIFT: at the next edge go to IDLE with `x`=0 and `x_valid`=0. No `done` pulse.
- `start` and `abort` both high in IDLE: `abort` wins and nothing is captured.
- `len`=0: `start` is ignored and no `done` pulse is produced.
- `len`>WIDTH: the captured length is clamped to WIDTH.
- `start` while `busy`=1: ignored; the captured registers are not disturbed.
- Input changes after capture have no effect on the transfer in progress.
- Reset values: `x`=0, `x_valid`=0, `busy`=0, `done`=0, state IDLE, all counters 0.

## Timing
- `start` sampled at edge k: first bit on `x` from edge k (zero-cycle registered latency).
  - `x_valid` and `busy` rise at the same edge k.
- N = `len`×(`rep`+1). Bits occupy edges k .. k+N-1.
  - `done` is high for the cycle after edge k+N.
  - `busy` and `x_valid` fall at edge k+N.
- Earliest accepted restart: `start` sampled at edge k+N+1, giving one idle bubble after DONE.
- `rst_n` low at any time (mid-pass included): outputs reach reset values immediately, with no clock required.
  - Release is synchronous to the next edge in the usual way. The first `start` can be accepted at the first edge after release.
- Counter widths: bit index is $clog2(WIDTH) bits; pass counter is REP_W bits; neither ever wraps below 0.

## Structure
- Package `serial_tx_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_SHIFT`, `ST_DONE`);
  - the default `WIDTH`/`REP_W` localparams;
  - a `clamp_len` function.
- One sub-module, `serial_tx_counter`: a down-counter with load, decrement and zero flag. It is instantiated twice, once as the bit index and once as the pass counter.
- The top level holds the FSM, the capture registers and the output registers.

## Test plan
- Reset then `pattern`=16'h00AD, `len`=8, `rep`=0, one-cycle `start` → `x` = 1,0,1,0,1,1,0,1 on 8 consecutive edges; `done` high once; a `moore_pass` downstream sees the identical stream.
- `pattern`=16'b101, `len`=3, `rep`=2 → `x` = 101101101, 9 contiguous `x_valid` cycles, no gaps, then a single `done`.
- `len`=16, `rep`=0, `abort` at bit 5 → `x_valid` drops next edge, no `done`, `busy`=0; a new `start` two cycles later sends correctly.
- `start` pulsed again mid-transfer with a different pattern → ignored; the original 8-bit stream completes unchanged.
- `len`=0 with `start` → no `busy` and no `done`. `len`=20 → exactly 16 bits are sent.
- `rst_n` driven low between clock edges during SHIFT → `x`, `x_valid`, `busy` go to 0 without a clock edge; after release, the FSM is in IDLE and accepts `start`.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types, default sizes and helpers for the serial pattern transmitter.
package serial_tx_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_REP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Limit a requested pattern length to the physical pattern width.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned width);
    return (len > width) ? width : len;
  endfunction

endpackage

// File: rtl/serial_tx_counter.sv
// Down-counter with synchronous load, saturating decrement and zero flag.
module serial_tx_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serializes a captured pattern MSB-first, repeated rep+1 times, one bit per clock.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned REP_W = DEF_REP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         pattern,
  input  logic [$clog2(WIDTH):0]   len,
  input  logic [REP_W-1:0]         rep,
  output logic                     x,
  output logic                     x_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned LEN_W = IDX_W + 1;

  state_t state_q, state_d;

  logic [WIDTH-1:0] pat_q;
  logic [IDX_W-1:0] last_idx_q;

  logic [LEN_W-1:0] len_clamped;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] idx_m1;

  logic             cap;
  logic             idx_load, idx_dec, idx_zero;
  logic [IDX_W-1:0] idx_val, idx;
  logic             pass_load, pass_dec, pass_zero;
  logic [REP_W-1:0] pass_val;
  logic [REP_W-1:0] unused_pass_cnt;

  logic x_d, x_valid_d, busy_d, done_d;

  assign len_clamped = LEN_W'(clamp_len(32'(len), WIDTH));
  assign start_idx   = IDX_W'(len_clamped - LEN_W'(1));
  assign idx_m1      = idx - IDX_W'(1);

  serial_tx_counter #(.W(IDX_W)) u_bit_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (idx_load),
    .dec      (idx_dec),
    .load_val (idx_val),
    .count    (idx),
    .zero     (idx_zero)
  );

  serial_tx_counter #(.W(REP_W)) u_pass_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pass_load),
    .dec      (pass_dec),
    .load_val (pass_val),
    .count    (unused_pass_cnt),
    .zero     (pass_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter controls and next output values.
  // The index counter holds the position of the bit currently on x, so the
  // next bit is fetched one below it (or from the top on a pass reload).
  always_comb begin
    state_d   = state_q;
    cap       = 1'b0;
    idx_load  = 1'b0;
    idx_dec   = 1'b0;
    idx_val   = '0;
    pass_load = 1'b0;
    pass_dec  = 1'b0;
    pass_val  = '0;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort && (len != '0)) begin
          cap       = 1'b1;
          idx_load  = 1'b1;
          idx_val   = start_idx;
          pass_load = 1'b1;
          pass_val  = rep;
          x_d       = pattern[start_idx];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!idx_zero) begin
          idx_dec   = 1'b1;
          x_d       = pat_q[idx_m1];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else if (!pass_zero) begin
          idx_load  = 1'b1;
          idx_val   = last_idx_q;
          pass_dec  = 1'b1;
          x_d       = pat_q[last_idx_q];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture registers; the reload index is stored instead of the raw length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q      <= '0;
      last_idx_q <= '0;
    end else if (cap) begin
      pat_q      <= pattern;
      last_idx_q <= start_idx;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      x       <= x_d;
      x_valid <= x_valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed self-checking bench for serial_pattern_tx.
module tb_serial_pattern_tx;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [3:0]  rep;
  logic        x;
  logic        x_valid;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  serial_pattern_tx #(.WIDTH(16), .REP_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .len     (len),
    .rep     (rep),
    .x       (x),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check_bit({tag, "_x"}, x, 1'b0);
    check_bit({tag, "_valid"}, x_valid, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, done, exp_done);
  endtask

  // Starts a transfer, checks every bit against exp_bits (first bit at
  // exp_bits[nexp-1]), then the done pulse. A start is re-pulsed after bit
  // index poke to show it is ignored while busy.
  task automatic send_and_check(input string tag, input logic [15:0] pat,
                                input logic [4:0] l, input logic [3:0] r,
                                input int nexp, input logic [15:0] exp_bits,
                                input int poke);
    pattern = pat;
    len     = l;
    rep     = r;
    abort   = 1'b0;
    start   = 1'b1;
    for (int i = 0; i < nexp; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        start   = 1'b0;
        pattern = ~pat;
        len     = 5'd1;
        rep     = '0;
      end
      if (i == poke + 1) start = 1'b0;
      check_bit($sformatf("%s_x%0d", tag, i), x, exp_bits[nexp-1-i]);
      check_bit($sformatf("%s_valid%0d", tag, i), x_valid, 1'b1);
      check_bit($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
      check_bit($sformatf("%s_nodone%0d", tag, i), done, 1'b0);
      if (i == poke) begin
        start   = 1'b1;
        pattern = 16'hFFFF;
        len     = 5'd16;
        rep     = 4'd15;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check_idle({tag, "_end"}, 1'b1);
    @(posedge clk);
    #1;
    check_idle({tag, "_after"}, 1'b0);
  endtask

  initial begin
    logic [5:0] abort_bits;
    abort_bits = 6'b101100;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    len     = '0;
    rep     = '0;
    #2;
    check_idle("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 8-bit pattern 0xAD, single pass.
    send_and_check("ad8", 16'h00AD, 5'd8, 4'd0, 8, 16'b10101101, -10);

    // 3-bit pattern repeated three times, back to back.
    send_and_check("rep3", 16'b101, 5'd3, 4'd2, 9, 16'b101101101, -10);

    // Abort after bit index 5 of a 16-bit transfer.
    pattern = 16'hB2C4;
    len     = 5'd16;
    rep     = 4'd0;
    start   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      check_bit($sformatf("abort_x%0d", i), x, abort_bits[5-i]);
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_idle("abort_edge", 1'b0);
    @(posedge clk);
    #1;
    check_idle("abort_gap", 1'b0);
    send_and_check("post_abort", 16'h00AD, 5'd8, 4'd0, 8, 16'b10101101, -10);

    // Start while busy is ignored.
    send_and_check("restart", 16'h0096, 5'd8, 4'd0, 8, 16'b10010110, 3);

    // start together with abort in idle: nothing happens.
    pattern = 16'hFFFF;
    len     = 5'd4;
    start   = 1'b1;
    abort   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check_idle("start_abort", 1'b0);

    // Zero length is ignored.
    pattern = 16'hFFFF;
    len     = 5'd0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_idle("len0_a", 1'b0);
    @(posedge clk);
    #1;
    check_idle("len0_b", 1'b0);

    // Oversized length is clamped to 16 bits.
    send_and_check("len20", 16'hC3A5, 5'd20, 4'd0, 16, 16'hC3A5, -10);

    // Asynchronous reset in the middle of a transfer.
    pattern = 16'hFFFF;
    len     = 5'd16;
    rep     = 4'd3;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_bit("pre_rst_valid", x_valid, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send_and_check("post_rst", 16'h00AD, 5'd8, 4'd0, 8, 16'b10101101, -10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
